// File: rtl/tl_resp_stub.sv
// TileLink slave stub with core-reset sequencer: holds the tile in reset, then
// answers A-channel requests in order with single-beat D acks after a minimum latency.
module tl_resp_stub #(
  parameter int unsigned ADDR_W       = 32,
  parameter int unsigned DATA_W       = 64,
  parameter int unsigned SRC_W        = 3,
  parameter int unsigned SIZE_W       = 3,
  parameter int unsigned SINK_W       = 2,
  parameter int unsigned DEPTH        = 4,
  parameter int unsigned LATENCY      = 1,
  parameter int unsigned RESET_CYCLES = 2
) (
  input  logic                         clock,
  input  logic                         reset,
  output logic                         core_reset,
  input  logic                         a_valid,
  output logic                         a_ready,
  input  logic [2:0]                   a_opcode,
  input  logic [2:0]                   a_param,
  input  logic [SIZE_W-1:0]            a_size,
  input  logic [SRC_W-1:0]             a_source,
  input  logic [ADDR_W-1:0]            a_address,
  input  logic [DATA_W/8-1:0]          a_mask,
  input  logic [DATA_W-1:0]            a_data,
  output logic                         d_valid,
  input  logic                         d_ready,
  output logic [2:0]                   d_opcode,
  output logic [1:0]                   d_param,
  output logic [SIZE_W-1:0]            d_size,
  output logic [SRC_W-1:0]             d_source,
  output logic [SINK_W-1:0]            d_sink,
  output logic [DATA_W-1:0]            d_data,
  output logic                         b_valid,
  output logic                         c_ready,
  output logic                         e_ready,
  input  logic [DATA_W-1:0]            rdata_in,
  input  logic                         stall_a,
  output logic [$clog2(DEPTH+1)-1:0]   outstanding,
  output logic                         err
);

  localparam int unsigned CNT_W    = $clog2(DEPTH + 1);
  localparam int unsigned PTR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned AGE_W    = $clog2(LATENCY + 1);
  localparam int unsigned RC_W     = $clog2(RESET_CYCLES + 1);
  localparam int unsigned MAX_SIZE = $clog2(DATA_W / 8);

  localparam logic [2:0] D_ACCESS_ACK      = 3'd0;
  localparam logic [2:0] D_ACCESS_ACK_DATA = 3'd1;
  localparam logic [2:0] D_HINT_ACK        = 3'd2;

  logic [RC_W-1:0]   rst_cnt;
  logic [PTR_W-1:0]  wptr, rptr;
  logic              a_fire, op_bad, enq, deq;
  logic [2:0]        resp_op;
  logic [DATA_W-1:0] resp_data;

  logic [2:0]        q_op   [DEPTH];
  logic [SIZE_W-1:0] q_size [DEPTH];
  logic [SRC_W-1:0]  q_src  [DEPTH];
  logic [DATA_W-1:0] q_data [DEPTH];
  logic [AGE_W-1:0]  q_age  [DEPTH];

  logic unused_ok;
  assign unused_ok = ^{a_param, a_address, a_mask, a_data};

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // Core-reset sequencer: count up after harness reset, release at RESET_CYCLES.
  always_ff @(posedge clock) begin
    if (reset) begin
      rst_cnt    <= '0;
      core_reset <= 1'b1;
    end else if (rst_cnt != RC_W'(RESET_CYCLES)) begin
      rst_cnt    <= rst_cnt + RC_W'(1);
      core_reset <= (rst_cnt + RC_W'(1)) != RC_W'(RESET_CYCLES);
    end
  end

  // Full queue refuses even when the head leaves this cycle.
  assign a_ready = !core_reset && !stall_a && (outstanding != CNT_W'(DEPTH));
  assign a_fire  = a_valid && a_ready;
  assign op_bad  = (a_opcode[2:1] == 2'b11);
  assign enq     = a_fire && !op_bad;
  assign d_valid = (outstanding != '0) && (q_age[rptr] == AGE_W'(LATENCY));
  assign deq     = d_valid && d_ready;

  always_comb begin
    resp_op   = D_ACCESS_ACK;
    resp_data = '0;
    case (a_opcode)
      3'd2, 3'd3, 3'd4: begin
        resp_op   = D_ACCESS_ACK_DATA;
        resp_data = rdata_in;
      end
      3'd5:    resp_op = D_HINT_ACK;
      default: ;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wptr        <= '0;
      rptr        <= '0;
      outstanding <= '0;
      err         <= 1'b0;
    end else begin
      if (enq) wptr <= ptr_inc(wptr);
      if (deq) rptr <= ptr_inc(rptr);
      if (enq && !deq)      outstanding <= outstanding + CNT_W'(1);
      else if (!enq && deq) outstanding <= outstanding - CNT_W'(1);
      if (a_fire && (op_bad || (32'(a_size) > MAX_SIZE))) err <= 1'b1;
    end
  end

  // Payload storage; age counts the acceptance cycle as 1 so LATENCY=1 answers next cycle.
  always_ff @(posedge clock) begin
    if (enq) begin
      q_op[wptr]   <= resp_op;
      q_size[wptr] <= a_size;
      q_src[wptr]  <= a_source;
      q_data[wptr] <= resp_data;
    end
    for (int i = 0; i < DEPTH; i++) begin
      if (enq && (wptr == PTR_W'(i)))          q_age[i] <= AGE_W'(1);
      else if (q_age[i] != AGE_W'(LATENCY))    q_age[i] <= q_age[i] + AGE_W'(1);
    end
  end

  assign d_opcode = d_valid ? q_op[rptr]   : '0;
  assign d_size   = d_valid ? q_size[rptr] : '0;
  assign d_source = d_valid ? q_src[rptr]  : '0;
  assign d_data   = d_valid ? q_data[rptr] : '0;
  assign d_param  = '0;
  assign d_sink   = '0;
  assign b_valid  = 1'b0;
  assign c_ready  = 1'b1;
  assign e_ready  = 1'b1;

endmodule

// File: tb/tb_tl_resp_stub.sv
// Directed bench for tl_resp_stub: instance A (DEPTH=4, LATENCY=1) and
// instance B (DEPTH=3, LATENCY=3) share stimulus; each test checks one of them.
module tb_tl_resp_stub;

  logic        clock = 1'b0;
  logic        reset;
  logic        a_valid, d_ready, stall_a;
  logic [2:0]  a_opcode, a_param, a_size, a_source;
  logic [31:0] a_address;
  logic [7:0]  a_mask;
  logic [63:0] a_data, rdata_in;

  logic        core_reset_a, a_ready_a, d_valid_a, b_valid_a, c_ready_a, e_ready_a, err_a;
  logic [2:0]  d_opcode_a, d_size_a, d_source_a, outstanding_a;
  logic [1:0]  d_param_a, d_sink_a;
  logic [63:0] d_data_a;

  logic        core_reset_b, a_ready_b, d_valid_b, b_valid_b, c_ready_b, e_ready_b, err_b;
  logic [2:0]  d_opcode_b, d_size_b, d_source_b;
  logic [1:0]  outstanding_b, d_param_b, d_sink_b;
  logic [63:0] d_data_b;

  int vecs = 0;
  int errs = 0;

  always #5 clock = ~clock;

  tl_resp_stub #(.DEPTH(4), .LATENCY(1), .RESET_CYCLES(2)) u_a (
    .clock(clock), .reset(reset), .core_reset(core_reset_a),
    .a_valid(a_valid), .a_ready(a_ready_a), .a_opcode(a_opcode), .a_param(a_param),
    .a_size(a_size), .a_source(a_source), .a_address(a_address), .a_mask(a_mask),
    .a_data(a_data), .d_valid(d_valid_a), .d_ready(d_ready), .d_opcode(d_opcode_a),
    .d_param(d_param_a), .d_size(d_size_a), .d_source(d_source_a), .d_sink(d_sink_a),
    .d_data(d_data_a), .b_valid(b_valid_a), .c_ready(c_ready_a), .e_ready(e_ready_a),
    .rdata_in(rdata_in), .stall_a(stall_a), .outstanding(outstanding_a), .err(err_a));

  tl_resp_stub #(.DEPTH(3), .LATENCY(3), .RESET_CYCLES(2)) u_b (
    .clock(clock), .reset(reset), .core_reset(core_reset_b),
    .a_valid(a_valid), .a_ready(a_ready_b), .a_opcode(a_opcode), .a_param(a_param),
    .a_size(a_size), .a_source(a_source), .a_address(a_address), .a_mask(a_mask),
    .a_data(a_data), .d_valid(d_valid_b), .d_ready(d_ready), .d_opcode(d_opcode_b),
    .d_param(d_param_b), .d_size(d_size_b), .d_source(d_source_b), .d_sink(d_sink_b),
    .d_data(d_data_b), .b_valid(b_valid_b), .c_ready(c_ready_b), .e_ready(e_ready_b),
    .rdata_in(rdata_in), .stall_a(stall_a), .outstanding(outstanding_b), .err(err_b));

  task automatic step;
    @(posedge clock);
    #1;
  endtask

  task automatic idle;
    a_valid = 1'b0; a_opcode = 3'd0; a_param = 3'd0; a_size = 3'd3; a_source = 3'd0;
    a_address = 32'h1000; a_mask = 8'hFF; a_data = 64'h0; rdata_in = 64'h0;
    d_ready = 1'b0; stall_a = 1'b0;
  endtask

  task automatic drive_a(input logic [2:0] op, input logic [2:0] src,
                         input logic [2:0] size, input logic [63:0] rd);
    a_valid = 1'b1; a_opcode = op; a_source = src; a_size = size; rdata_in = rd;
  endtask

  task automatic bringup;
    idle();
    reset = 1'b1;
    step(); step();
    reset = 1'b0;
    step(); step();
  endtask

  task automatic test_reset;
    idle();
    reset = 1'b1;
    step(); #1;
    vecs++;
    if ({core_reset_a, a_ready_a, d_valid_a, err_a, b_valid_a, c_ready_a, e_ready_a} !== 7'b1000011) begin
      errs++; $display("FAIL reset_flags_a got %b exp 1000011",
        {core_reset_a, a_ready_a, d_valid_a, err_a, b_valid_a, c_ready_a, e_ready_a});
    end
    vecs++;
    if ({outstanding_a, d_opcode_a, d_param_a, d_size_a, d_source_a, d_sink_a, d_data_a} !== '0) begin
      errs++; $display("FAIL reset_d_fields_a got outstanding=%0d opcode=%0d data=%0h exp 0",
        outstanding_a, d_opcode_a, d_data_a);
    end
    vecs++;
    if ({core_reset_b, a_ready_b, d_valid_b, err_b, b_valid_b, c_ready_b, e_ready_b, outstanding_b,
         d_opcode_b, d_param_b, d_size_b, d_source_b, d_sink_b, d_data_b} !== {7'b1000011, 79'd0}) begin
      errs++; $display("FAIL reset_state_b got core_reset=%b d_valid=%b outstanding=%0d exp 1 0 0",
        core_reset_b, d_valid_b, outstanding_b);
    end
    step(); step();
    reset = 1'b0;
    for (int c = 0; c < 3; c++) begin
      #1;
      vecs++;
      if ({core_reset_a, a_ready_a} !== ((c < 2) ? 2'b10 : 2'b01)) begin
        errs++; $display("FAIL reset_release_cycle%0d got core_reset=%b a_ready=%b exp %b %b",
          c, core_reset_a, a_ready_a, c < 2, c >= 2);
      end
      if (c < 2) step();
    end
  endtask

  task automatic test_get_path;
    bringup();
    d_ready = 1'b1;
    drive_a(3'd4, 3'd5, 3'd3, 64'hDEAD_BEEF_0123_4567);
    #1;
    vecs++;
    if (a_ready_a !== 1'b1) begin errs++; $display("FAIL get_a_ready got %b exp 1", a_ready_a); end
    step();
    a_valid = 1'b0; rdata_in = 64'h0; #1;
    vecs++;
    if ({d_valid_a, d_opcode_a, d_source_a, d_size_a, d_param_a, d_sink_a} !== {1'b1, 3'd1, 3'd5, 3'd3, 2'd0, 2'd0}) begin
      errs++; $display("FAIL get_d_fields got v=%b op=%0d src=%0d size=%0d exp 1 1 5 3",
        d_valid_a, d_opcode_a, d_source_a, d_size_a);
    end
    vecs++;
    if (d_data_a !== 64'hDEAD_BEEF_0123_4567) begin
      errs++; $display("FAIL get_d_data got %h exp deadbeef01234567", d_data_a);
    end
    vecs++;
    if (outstanding_a !== 3'd1) begin errs++; $display("FAIL get_outstanding got %0d exp 1", outstanding_a); end
    step();
    vecs++;
    if ({d_valid_a, outstanding_a, err_a} !== 5'b0_000_0) begin
      errs++; $display("FAIL get_drained got v=%b out=%0d err=%b exp 0 0 0", d_valid_a, outstanding_a, err_a);
    end
  endtask

  task automatic test_back_to_back;
    d_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      if (i < 4) drive_a((i % 2 == 1) ? 3'd3 : 3'd2, 3'(i), 3'd3, 64'h1111_0000_0000_0000 + 64'(i));
      else a_valid = 1'b0;
      #1;
      if (i < 4) begin
        vecs++;
        if (a_ready_a !== 1'b1) begin errs++; $display("FAIL b2b_a_ready%0d got %b exp 1", i, a_ready_a); end
      end
      if (i > 0) begin
        vecs++;
        if ({d_valid_a, d_opcode_a, d_source_a, outstanding_a} !== {1'b1, 3'd1, 3'(i - 1), 3'd1} ||
            d_data_a !== 64'h1111_0000_0000_0000 + 64'(i - 1)) begin
          errs++; $display("FAIL b2b_resp%0d got v=%b src=%0d data=%h out=%0d exp 1 %0d %h 1",
            i - 1, d_valid_a, d_source_a, d_data_a, outstanding_a, i - 1, 64'h1111_0000_0000_0000 + 64'(i - 1));
        end
      end
      step();
    end
    vecs++;
    if ({d_valid_a, outstanding_a} !== 4'b0_000) begin
      errs++; $display("FAIL b2b_end got v=%b out=%0d exp 0 0", d_valid_a, outstanding_a);
    end
  endtask

  task automatic test_fill_backpressure;
    logic [2:0] exp_src [5];
    exp_src = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd7};
    d_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      drive_a(3'd0, 3'(i), 3'd3, 64'hFFFF);
      #1;
      vecs++;
      if (a_ready_a !== (i < 4)) begin
        errs++; $display("FAIL fill_a_ready%0d got %b exp %b", i, a_ready_a, i < 4);
      end
      step();
    end
    a_valid = 1'b0; #1;
    vecs++;
    if ({outstanding_a, a_ready_a, d_valid_a, d_opcode_a, d_source_a} !== {3'd4, 1'b0, 1'b1, 3'd0, 3'd0} ||
        d_data_a !== 64'd0) begin
      errs++; $display("FAIL fill_full got out=%0d rdy=%b v=%b op=%0d src=%0d data=%h exp 4 0 1 0 0 0",
        outstanding_a, a_ready_a, d_valid_a, d_opcode_a, d_source_a, d_data_a);
    end
    step();
    vecs++;
    if ({d_valid_a, d_source_a} !== {1'b1, 3'd0}) begin
      errs++; $display("FAIL fill_hold got v=%b src=%0d exp 1 0", d_valid_a, d_source_a);
    end
    d_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      if (k == 0)      drive_a(3'd0, 3'd6, 3'd3, 64'h0);
      else if (k == 1) drive_a(3'd1, 3'd7, 3'd3, 64'h0);
      else             a_valid = 1'b0;
      #1;
      if (k < 2) begin
        vecs++;
        if (a_ready_a !== (k == 1)) begin
          errs++; $display("FAIL drain_a_ready%0d got %b exp %b", k, a_ready_a, k == 1);
        end
      end
      vecs++;
      if ({d_valid_a, d_opcode_a, d_source_a} !== {1'b1, 3'd0, exp_src[k]}) begin
        errs++; $display("FAIL drain_resp%0d got v=%b op=%0d src=%0d exp 1 0 %0d",
          k, d_valid_a, d_opcode_a, d_source_a, exp_src[k]);
      end
      step();
      if (k == 1) begin
        vecs++;
        if (outstanding_a !== 3'd3) begin
          errs++; $display("FAIL drain_enq_deq_out got %0d exp 3", outstanding_a);
        end
      end
    end
    a_valid = 1'b0; #1;
    vecs++;
    if ({d_valid_a, outstanding_a} !== 4'b0_000) begin
      errs++; $display("FAIL drain_end got v=%b out=%0d exp 0 0", d_valid_a, outstanding_a);
    end
  endtask

  task automatic test_size_err;
    d_ready = 1'b1;
    #1;
    vecs++;
    if (err_a !== 1'b0) begin errs++; $display("FAIL size_err_pre got %b exp 0", err_a); end
    drive_a(3'd4, 3'd1, 3'd4, 64'h5A);
    step();
    a_valid = 1'b0; #1;
    vecs++;
    if ({err_a, d_valid_a, d_size_a, d_source_a} !== {1'b1, 1'b1, 3'd4, 3'd1} || d_data_a !== 64'h5A) begin
      errs++; $display("FAIL size_err got err=%b v=%b size=%0d src=%0d data=%h exp 1 1 4 1 5a",
        err_a, d_valid_a, d_size_a, d_source_a, d_data_a);
    end
    step();
  endtask

  task automatic test_latency_stall;
    bringup();
    d_ready = 1'b1;
    stall_a = 1'b1;
    drive_a(3'd5, 3'd2, 3'd0, 64'hABCD);
    #1;
    vecs++;
    if ({a_ready_b, a_ready_a} !== 2'b00) begin
      errs++; $display("FAIL stall_a_ready got b=%b a=%b exp 0 0", a_ready_b, a_ready_a);
    end
    step();
    vecs++;
    if (outstanding_b !== 2'd0) begin errs++; $display("FAIL stall_no_enq got %0d exp 0", outstanding_b); end
    stall_a = 1'b0; #1;
    vecs++;
    if (a_ready_b !== 1'b1) begin errs++; $display("FAIL unstall_a_ready got %b exp 1", a_ready_b); end
    step();
    a_valid = 1'b0;
    for (int c = 1; c <= 3; c++) begin
      #1;
      vecs++;
      if (d_valid_b !== (c == 3)) begin
        errs++; $display("FAIL lat3_cycle%0d d_valid got %b exp %b", c, d_valid_b, c == 3);
      end
      if (c == 3) begin
        vecs++;
        if ({d_opcode_b, d_source_b} !== {3'd2, 3'd2} || d_data_b !== 64'd0) begin
          errs++; $display("FAIL hint_ack got op=%0d src=%0d data=%h exp 2 2 0", d_opcode_b, d_source_b, d_data_b);
        end
      end
      step();
    end
    vecs++;
    if ({d_valid_b, outstanding_b} !== 3'b0_00) begin
      errs++; $display("FAIL lat3_end got v=%b out=%0d exp 0 0", d_valid_b, outstanding_b);
    end
  endtask

  task automatic test_wrap;
    logic [63:0] exp_q [$];
    logic [63:0] e;
    int sent = 0;
    int got = 0;
    bringup();
    for (int cyc = 0; cyc < 300 && got < 10; cyc++) begin
      d_ready = cyc[0];
      if (sent < 10) drive_a(3'd4, 3'(sent % 8), 3'd3, 64'hC0DE_0000 + 64'(sent));
      else a_valid = 1'b0;
      #1;
      if (d_valid_b && d_ready) begin
        vecs++;
        if (exp_q.size() == 0) begin
          errs++; $display("FAIL wrap_extra_resp got data=%h exp none", d_data_b);
        end else begin
          e = exp_q.pop_front();
          if (d_data_b !== e || d_source_b !== e[2:0]) begin
            errs++; $display("FAIL wrap_order got data=%h src=%0d exp %h %0d", d_data_b, d_source_b, e, e[2:0]);
          end
        end
        got++;
      end
      if (a_valid && a_ready_b) begin
        exp_q.push_back(64'hC0DE_0000 + 64'(sent));
        sent++;
      end
      step();
    end
    a_valid = 1'b0; d_ready = 1'b0; #1;
    vecs++;
    if (got !== 10 || sent !== 10 || exp_q.size() != 0 || outstanding_b !== 2'd0) begin
      errs++; $display("FAIL wrap_count got resp=%0d sent=%0d left=%0d out=%0d exp 10 10 0 0",
        got, sent, exp_q.size(), outstanding_b);
    end
  endtask

  task automatic test_err_reset;
    bringup();
    #1;
    vecs++;
    if (err_a !== 1'b0) begin errs++; $display("FAIL err_cleared got %b exp 0", err_a); end
    drive_a(3'd6, 3'd3, 3'd3, 64'h0);
    #1;
    vecs++;
    if (a_ready_a !== 1'b1) begin errs++; $display("FAIL acquire_a_ready got %b exp 1", a_ready_a); end
    step();
    a_valid = 1'b0; #1;
    vecs++;
    if ({err_a, outstanding_a, d_valid_a} !== {1'b1, 3'd0, 1'b0}) begin
      errs++; $display("FAIL acquire_err got err=%b out=%0d v=%b exp 1 0 0", err_a, outstanding_a, d_valid_a);
    end
    for (int i = 0; i < 2; i++) begin
      drive_a(3'd0, 3'(i), 3'd3, 64'h0);
      step();
    end
    a_valid = 1'b0; #1;
    vecs++;
    if ({outstanding_a, d_valid_a} !== {3'd2, 1'b1}) begin
      errs++; $display("FAIL pre_reset_queue got out=%0d v=%b exp 2 1", outstanding_a, d_valid_a);
    end
    reset = 1'b1;
    step();
    vecs++;
    if ({outstanding_a, d_valid_a, err_a, core_reset_a, a_ready_a} !== {3'd0, 1'b0, 1'b0, 1'b1, 1'b0}) begin
      errs++; $display("FAIL mid_reset got out=%0d v=%b err=%b core_reset=%b rdy=%b exp 0 0 0 1 0",
        outstanding_a, d_valid_a, err_a, core_reset_a, a_ready_a);
    end
    reset = 1'b0;
    step(); step();
    drive_a(3'd7, 3'd0, 3'd3, 64'h0);
    step();
    a_valid = 1'b0; #1;
    vecs++;
    if ({err_a, outstanding_a} !== {1'b1, 3'd0}) begin
      errs++; $display("FAIL opcode7_err got err=%b out=%0d exp 1 0", err_a, outstanding_a);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1);
  end

  initial begin
    reset = 1'b1;
    idle();
    test_reset();
    test_get_path();
    test_back_to_back();
    test_fill_backpressure();
    test_size_err();
    test_latency_stall();
    test_wrap();
    test_err_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
